// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch and F/D pipeline register with address-error tagging
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int          IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_F,
    output logic [31:0] IR_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        addr_err_D,
    output logic [31:0] fetch_cnt
);
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;
    logic [32:0] off;
    logic        fetch_ok;
    always_comb begin
        off      = {1'b0, pc_F} - {1'b0, IMEM_BASE};
        fetch_ok = (pc_F[1:0] == 2'b00) && (pc_F >= IMEM_BASE) && (off < LIMIT);
    end
    assign imem_addr = pc_F;
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F       <= PC_RESET;
            IR_D       <= '0;
            pc_D       <= '0;
            pc4_D      <= '0;
            pc8_D      <= '0;
            valid_D    <= 1'b0;
            addr_err_D <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            if (!stall_F) pc_F <= npc;
            if (!stall_D) begin
                if (flush_D) begin
                    IR_D       <= '0;
                    pc_D       <= '0;
                    pc4_D      <= '0;
                    pc8_D      <= '0;
                    valid_D    <= 1'b0;
                    addr_err_D <= 1'b0;
                end else begin
                    IR_D       <= fetch_ok ? imem_rdata : 32'h0;
                    pc_D       <= pc_F;
                    pc4_D      <= pc_F + 32'd4;
                    pc8_D      <= pc_F + 32'd8;
                    valid_D    <= 1'b1;
                    addr_err_D <= !fetch_ok;
                    fetch_cnt  <= fetch_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table, corner sequences and randomized run against a behavioural model
module tb_fetch_stage;
    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int WORDS = 4096;
    logic clk = 1'b0;
    logic reset, stall_F, stall_D, flush_D;
    logic [31:0] npc, imem_rdata, imem_addr, pc_F, IR_D, pc_D, pc4_D, pc8_D, fetch_cnt;
    logic valid_D, addr_err_D;
    logic [31:0] mem [WORDS];
    int n_chk = 0, n_fail = 0;
    logic [31:0] m_pc, m_ir, m_pcd, m_cnt;
    logic m_val, m_err;

    fetch_stage dut (
        .clk(clk), .reset(reset), .npc(npc), .stall_F(stall_F), .stall_D(stall_D),
        .flush_D(flush_D), .imem_rdata(imem_rdata), .imem_addr(imem_addr), .pc_F(pc_F),
        .IR_D(IR_D), .pc_D(pc_D), .pc4_D(pc4_D), .pc8_D(pc8_D), .valid_D(valid_D),
        .addr_err_D(addr_err_D), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_addr >= BASE && imem_addr - BASE < 32'(4 * WORDS))
            imem_rdata = mem[(imem_addr - BASE) >> 2];
    end

    typedef struct {
        logic r, sf, sd, fl;
        logic [31:0] npc, pc, ir, pcd;
        logic val, err;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl [23];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] n, input logic sf, input logic sd, input logic fl);
        longint p;
        bit ok;
        reset = r; npc = n; stall_F = sf; stall_D = sd; flush_D = fl;
        p  = longint'(m_pc);
        ok = (p % 4 == 0) && (p >= longint'(BASE)) && (p - longint'(BASE) < 4 * WORDS);
        if (r) begin
            m_pc = BASE; m_ir = 0; m_pcd = 0; m_val = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (!sd && fl) begin
                m_ir = 0; m_pcd = 0; m_val = 0; m_err = 0;
            end else if (!sd) begin
                m_ir  = ok ? mem[int'((p - longint'(BASE)) / 4)] : 32'h0;
                m_pcd = m_pc; m_val = 1; m_err = !ok; m_cnt = m_cnt + 1;
            end
            if (!sf) m_pc = n;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_F", pc_F, m_pc);
        chk("IR_D", IR_D, m_ir);
        chk("pc_D", pc_D, m_pcd);
        chk("pc4_D", pc4_D, m_val ? m_pcd + 4 : 32'h0);
        chk("pc8_D", pc8_D, m_val ? m_pcd + 8 : 32'h0);
        chk("valid_D", {31'h0, valid_D}, {31'h0, m_val});
        chk("addr_err_D", {31'h0, addr_err_D}, {31'h0, m_err});
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hAC00_0000 + 32'(i);
        mem[0] = 32'h2408_0001;
        mem[1] = 32'h2409_0002;
        m_pc = 0; m_ir = 0; m_pcd = 0; m_val = 0; m_err = 0; m_cnt = 0;
        tbl = '{
            '{1'b1,1'b0,1'b0,1'b0, 32'h0,    32'h3000, 32'h0,         32'h0,    1'b0,1'b0, 32'd0},
            '{1'b1,1'b0,1'b0,1'b0, 32'h0,    32'h3000, 32'h0,         32'h0,    1'b0,1'b0, 32'd0},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3004, 32'h3004, 32'h2408_0001, 32'h3000, 1'b1,1'b0, 32'd1},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3008, 32'h3008, 32'h2409_0002, 32'h3004, 1'b1,1'b0, 32'd2},
            '{1'b0,1'b1,1'b1,1'b0, 32'h300C, 32'h3008, 32'h2409_0002, 32'h3004, 1'b1,1'b0, 32'd2},
            '{1'b0,1'b1,1'b1,1'b0, 32'h300C, 32'h3008, 32'h2409_0002, 32'h3004, 1'b1,1'b0, 32'd2},
            '{1'b0,1'b1,1'b1,1'b0, 32'h300C, 32'h3008, 32'h2409_0002, 32'h3004, 1'b1,1'b0, 32'd2},
            '{1'b0,1'b0,1'b0,1'b0, 32'h300C, 32'h300C, 32'hAC00_0002, 32'h3008, 1'b1,1'b0, 32'd3},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3100, 32'h3100, 32'hAC00_0003, 32'h300C, 1'b1,1'b0, 32'd4},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3104, 32'h3104, 32'hAC00_0040, 32'h3100, 1'b1,1'b0, 32'd5},
            '{1'b0,1'b0,1'b0,1'b1, 32'h3108, 32'h3108, 32'h0,         32'h0,    1'b0,1'b0, 32'd5},
            '{1'b0,1'b0,1'b0,1'b0, 32'h310C, 32'h310C, 32'hAC00_0042, 32'h3108, 1'b1,1'b0, 32'd6},
            '{1'b0,1'b0,1'b1,1'b1, 32'h3110, 32'h3110, 32'hAC00_0042, 32'h3108, 1'b1,1'b0, 32'd6},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3002, 32'h3002, 32'hAC00_0044, 32'h3110, 1'b1,1'b0, 32'd7},
            '{1'b0,1'b0,1'b0,1'b0, 32'h7000, 32'h7000, 32'h0,         32'h3002, 1'b1,1'b1, 32'd8},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3000, 32'h3000, 32'h0,         32'h7000, 1'b1,1'b1, 32'd9},
            '{1'b0,1'b1,1'b0,1'b0, 32'h3004, 32'h3000, 32'h2408_0001, 32'h3000, 1'b1,1'b0, 32'd10},
            '{1'b0,1'b1,1'b0,1'b0, 32'h3004, 32'h3000, 32'h2408_0001, 32'h3000, 1'b1,1'b0, 32'd11},
            '{1'b0,1'b0,1'b1,1'b0, 32'h3004, 32'h3004, 32'h2408_0001, 32'h3000, 1'b1,1'b0, 32'd11},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3008, 32'h3008, 32'h2409_0002, 32'h3004, 1'b1,1'b0, 32'd12},
            '{1'b0,1'b0,1'b0,1'b0, 32'h6FFC, 32'h6FFC, 32'hAC00_0002, 32'h3008, 1'b1,1'b0, 32'd13},
            '{1'b0,1'b0,1'b0,1'b0, 32'h2FFC, 32'h2FFC, 32'hAC00_0FFF, 32'h6FFC, 1'b1,1'b0, 32'd14},
            '{1'b0,1'b0,1'b0,1'b0, 32'h3000, 32'h3000, 32'h0,         32'h2FFC, 1'b1,1'b1, 32'd15}
        };
        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].npc, tbl[i].sf, tbl[i].sd, tbl[i].fl);
            chk($sformatf("tbl%0d.pc_F", i), pc_F, tbl[i].pc);
            chk($sformatf("tbl%0d.IR_D", i), IR_D, tbl[i].ir);
            chk($sformatf("tbl%0d.pc_D", i), pc_D, tbl[i].pcd);
            chk($sformatf("tbl%0d.pc8_D", i), pc8_D, tbl[i].val ? tbl[i].pcd + 8 : 32'h0);
            chk($sformatf("tbl%0d.valid_D", i), {31'h0, valid_D}, {31'h0, tbl[i].val});
            chk($sformatf("tbl%0d.addr_err_D", i), {31'h0, addr_err_D}, {31'h0, tbl[i].err});
            chk($sformatf("tbl%0d.fetch_cnt", i), fetch_cnt, tbl[i].cnt);
        end
        // counter wrap: preload the count just below the wrap point
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b0, 32'h3004, 1'b0, 1'b0, 1'b0);
        chk("wrap.fetch_cnt", fetch_cnt, 32'h0);
        step(1'b0, 32'h3008, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h3100, 1'b1, 1'b1, 1'b1);
        chk("rst_stall.pc_F", pc_F, 32'h3000);
        chk("rst_stall.IR_D", IR_D, 32'h0);
        chk("rst_stall.pc4_D", pc4_D, 32'h0);
        chk("rst_stall.valid_D", {31'h0, valid_D}, 32'h0);
        chk("rst_stall.fetch_cnt", fetch_cnt, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] n;
            int k;
            k = $urandom_range(0, 99);
            n = (k < 70) ? m_pc + 4 :
                (k < 88) ? BASE + (32'($urandom_range(0, WORDS - 1)) << 2) :
                (k < 94) ? BASE + 32'($urandom_range(0, 4 * WORDS - 1)) : $urandom;
            step($urandom_range(0, 99) < 2, n, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the five-stage pipelined MIPS core. Holds the program counter, drives the instruction-memory address, and captures the fetched word into the F/D pipeline register. Upstream of the next-PC logic: it produces `pc_F`, `IR_D`, `pc4_D` and `pc8_D`, and loads `npc` back into the PC every unstalled cycle. Stall and flush inputs come from the hazard unit. The block adds address-error tagging and a retired-fetch counter.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `IMEM_BASE`, 32'h0000_3000, byte address of instruction-memory word 0.
- `IMEM_WORDS`, 4096, number of 32-bit words in instruction memory.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `clk`  in  1  rising-edge clock.
  - `reset`  in  1  synchronous, active-high reset.
- Inputs:
  - `npc`  in  32  next PC from next-PC logic.
  - `stall_F`  in  1  hold the PC register.
  - `stall_D`  in  1  hold the F/D register.
  - `flush_D`  in  1  load a bubble into the F/D register.
  - `imem_rdata`  in  32  instruction word at `imem_addr`, combinational.
- Outputs:
  - `imem_addr`  out  32  equals `pc_F`.
  - `pc_F`  out  32  current fetch PC, registered.
  - `IR_D`  out  32  instruction in Decode.
  - `pc_D`  out  32  PC of `IR_D`.
  - `pc4_D`  out  32  `pc_D`+4.
  - `pc8_D`  out  32  `pc_D`+8, the link value.
  - `valid_D`  out  1  `IR_D` holds a real fetched instruction, not a bubble.
  - `addr_err_D`  out  1  `IR_D` came from a misaligned or out-of-range PC.
  - `fetch_cnt`  out  32  count of valid instructions loaded into D.

## Operation
- **PC register**
  - `reset`: `pc_F`←`PC_RESET`.
  - `stall_F`: hold.
  - Otherwise `pc_F`←`npc`. The block does not increment the PC itself; next-PC logic returns `pc_F`+4 for sequential flow.
- **Fetch check.** `fetch_ok` = (`pc_F[1:0]`==0) && (`pc_F`≥`IMEM_BASE`) && (`pc_F`−`IMEM_BASE` < 4·`IMEM_WORDS`). Use 33-bit unsigned compare; no wrap.
- **F/D register update priority** (highest first):
  1. `reset`: `IR_D`=0, `pc_D`=`pc4_D`=`pc8_D`=0, `valid_D`=0, `addr_err_D`=0.
  2. `stall_D`: all F/D fields hold.
  3. `flush_D`: same values as reset. `fetch_cnt` unchanged.
  4. Normal load:
     - `pc_D`←`pc_F`, `pc4_D`←`pc_F`+4, `pc8_D`←`pc_F`+8, all mod 2^32.
     - `IR_D`←`fetch_ok` ? `imem_rdata` : 0 (nop).
     - `valid_D`←1, `addr_err_D`←!`fetch_ok`.
- **fetch_cnt**
  - Reset to 0.
  - +1 on each normal load.
  - Wraps 0xFFFF_FFFF→0.
- **Delay slot.** The branch/jump delay slot is never flushed by this block; `flush_D` is used only by external exception/redirect logic.
- **Stall pairing.**
  - `stall_F`=1 with `stall_D`=0 is legal: D loads the same PC again, duplicating that instruction.
  - `stall_F`=0 with `stall_D`=1 is legal: the PC advances while D holds. The instruction at the old `pc_F` is dropped.
  - The hazard unit drives both stalls together; the bench checks both legal mismatches.

## Timing
- `imem_addr` = `pc_F` combinationally. `imem_rdata` is sampled at the same rising edge into `IR_D`, giving one cycle of fetch latency.
- After reset deasserts, cycle 0 (reset low): `pc_F`=`PC_RESET`, `valid_D`=0.
- At the first edge with reset low, D loads the instruction at `PC_RESET`. It is visible in cycle 1.
- The redirect path `npc`→`pc_F` is one edge.
- All outputs change only on rising `clk`. No combinational path from `npc`, `stall_*` or `flush_D` to any output.
- `reset` mid-stall or mid-flush overrides both in the same edge.

## Test plan
- **Reset and sequential fetch.**
  - Stimulus: hold reset 2 cycles, release. `npc`=`pc_F`+4 each cycle. Memory returns 0x2408_0001, 0x2409_0002.
  - Required: cycle 0 `pc_F`=0x3000, `valid_D`=0.
  - Required: cycle 1 `IR_D`=0x2408_0001, `pc_D`=0x3000, `pc8_D`=0x3008.
  - Required: cycle 2 `pc_D`=0x3004, `fetch_cnt`=2.
- **Stall.**
  - Stimulus: `stall_F`=`stall_D`=1 for 3 cycles at `pc_F`=0x3008.
  - Required: `pc_F`, `IR_D`, `pc_D` and `fetch_cnt` all hold.
  - Required: after release, `pc_D`=0x3008 loads on the next edge.
- **Redirect.**
  - Stimulus: `npc`=0x3100 for one cycle.
  - Required: the next `pc_F` is 0x3100.
  - Required: D gets the delay-slot instruction first, then 0x3100.
- **Flush vs stall priority.**
  - Stimulus: `flush_D` alone.
  - Required: `IR_D`=0, `valid_D`=0, counter unchanged.
  - Stimulus: `flush_D`=`stall_D`=1.
  - Required: D holds its prior contents.
- **Address error.**
  - Stimulus: `npc`=0x3002, then `npc`=0x7000 (beyond 0x3000+16 KiB).
  - Required: each load gives `IR_D`=0, `addr_err_D`=1, `valid_D`=1.
- **Reset mid-operation and counter wrap.**
  - Stimulus: preload `fetch_cnt` near wrap via a 2^32-cycle-equivalent force of 0xFFFF_FFFF, then one normal load.
  - Required: `fetch_cnt`=0.
  - Stimulus: assert reset during a stall.
  - Required: every output returns to its reset value in one edge.
